// File: rtl/htif_pkg.sv
// Shared state encoding and HTIF device/command codes for htif_monitor.
package htif_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } htif_state_e;

  localparam logic [7:0] HTIF_DEV_SYSCALL = 8'd0;
  localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
  localparam logic [7:0] HTIF_CMD_PUTCHAR = 8'd1;

endpackage

// File: rtl/htif_monitor_if.sv
// Data-memory store bus observed by htif_monitor; the core drives, the monitor listens.
interface htif_monitor_if;
  // Strobe-only bus with no back-pressure: a store is taken on every clock
  // edge where storeValid is high; byteEnable selects the written lanes.
  logic        storeValid;
  logic [31:0] d_address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;

  modport master (output storeValid, d_address, storeData, byteEnable);
  modport slave  (input  storeValid, d_address, storeData, byteEnable);
endinterface

// File: rtl/htif_watchdog.sv
// Saturating RUN-cycle counter; flags the edge on which the count reaches TIMEOUT.
module htif_watchdog #(
  parameter int unsigned TIMEOUT = 200_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] cycle_count,
  output logic        timeout_hit
);

  logic [31:0] count_next;

  assign count_next  = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
  // Hit is raised while the count is about to become TIMEOUT, so halt and the
  // final count appear together and the count freezes at exactly TIMEOUT.
  assign timeout_hit = run && (count_next == TIMEOUT);

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (run) begin
      cycle_count <= count_next;
    end
  end

endmodule

// File: rtl/htif_monitor.sv
// HTIF tohost monitor: exit/timeout detection, drain delay, optional console
// output compiled in with macro HTIF_CONSOLE_EN.
module htif_monitor
  import htif_pkg::*;
#(
  parameter logic [31:0] TOHOST  = 32'h0000_1000,
  parameter int unsigned TIMEOUT = 200_000,
  parameter int unsigned DRAIN   = 4
) (
  input  logic          clock,
  input  logic          reset,
  htif_monitor_if.slave bus,
  output logic          halt,
  output logic          done,
  output logic          pass,
  output logic [30:0]   exit_code,
  output logic          timeout,
  output logic          char_valid,
  output logic [7:0]    char_data,
  output logic [31:0]   cycle_count,
  output htif_state_e   state
);

  localparam int DW = $clog2(DRAIN + 1) + 1;

  htif_state_e   state_q, state_d;
  logic [7:0]    hi_dev;
  logic [DW-1:0] drain_cnt;
  logic          in_run, full_word, wr_lo, hi_we;
  logic          exit_fire, timeout_hit, timeout_fire, drain_end;

  assign state     = state_q;
  assign in_run    = (state_q == ST_RUN);
  assign full_word = bus.storeValid && (bus.byteEnable == 4'b1111);
  assign wr_lo     = full_word && (bus.d_address == TOHOST);
  assign hi_we     = in_run && full_word && (bus.d_address == TOHOST + 32'd4);

  assign exit_fire    = in_run && wr_lo && (hi_dev == HTIF_DEV_SYSCALL) && bus.storeData[0];
  assign timeout_fire = timeout_hit && !exit_fire;
  assign drain_end    = (state_q == ST_DRAIN) && (drain_cnt == DW'(DRAIN));

  htif_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock       (clock),
    .reset       (reset),
    .run         (in_run),
    .cycle_count (cycle_count),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (exit_fire || timeout_fire) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_dev    <= 8'd0;
      drain_cnt <= '0;
      halt      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      exit_code <= 31'd0;
      timeout   <= 1'b0;
    end else begin
      if (hi_we) hi_dev <= bus.storeData[31:24];
      if (exit_fire) begin
        halt      <= 1'b1;
        pass      <= (bus.storeData == 32'd1);
        exit_code <= bus.storeData[31:1];
        timeout   <= 1'b0;
      end else if (timeout_fire) begin
        halt      <= 1'b1;
        pass      <= 1'b0;
        exit_code <= 31'd0;
        timeout   <= 1'b1;
      end
      if (state_q == ST_DRAIN) drain_cnt <= drain_cnt + DW'(1);
      done <= (state_d == ST_DONE);
    end
  end

`ifdef HTIF_CONSOLE_EN
  logic [7:0] hi_cmd;
  logic       char_fire;

  assign char_fire = in_run && wr_lo && (hi_dev == HTIF_DEV_CONSOLE) && (hi_cmd == HTIF_CMD_PUTCHAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_cmd     <= 8'd0;
      char_valid <= 1'b0;
      char_data  <= 8'd0;
    end else begin
      if (hi_we) hi_cmd <= bus.storeData[23:16];
      char_valid <= char_fire;
      if (char_fire) char_data <= bus.storeData[7:0];
    end
  end
`else
  assign char_valid = 1'b0;
  assign char_data  = 8'd0;
`endif

endmodule

// File: tb/tb_htif_monitor.sv
// Bench for htif_monitor: vector table, directed multi-cycle cases and
// randomized stores checked cycle by cycle against a behavioural model.
module tb_htif_monitor;
  import htif_pkg::*;

  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned DRAIN   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halt, done, pass, timeout, char_valid;
  logic [30:0] exit_code;
  logic [7:0]  char_data;
  logic [31:0] cycle_count;
  htif_state_e state;

  htif_monitor_if bus_if();

  htif_monitor #(.TOHOST(TOHOST), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if.slave),
    .halt        (halt),
    .done        (done),
    .pass        (pass),
    .exit_code   (exit_code),
    .timeout     (timeout),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .cycle_count (cycle_count),
    .state       (state)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_running;
  longint unsigned m_cycles;
  logic [31:0]     m_hi;
  bit              m_halt, m_pass, m_timeout, m_char_v;
  logic [30:0]     m_code;
  int              m_since;

  function automatic void model_step(bit sv, logic [31:0] addr, logic [31:0] data,
                                     logic [3:0] be, bit rst);
    bit full, stopped;
    longint unsigned nc;
    if (rst) begin
      m_running = 1; m_cycles = 0; m_hi = 0; m_halt = 0; m_pass = 0;
      m_timeout = 0; m_code = 0; m_since = 0; m_char_v = 0;
      exp_q.delete();
      return;
    end
    m_char_v = 0;
    if (!m_running) begin
      m_since++;
      return;
    end
    full    = sv && (be == 4'hF);
    stopped = 0;
    nc      = (m_cycles >= 64'hFFFF_FFFF) ? m_cycles : m_cycles + 1;
    if (full && addr == TOHOST + 32'd4) begin
      m_hi = data;
    end else if (full && addr == TOHOST && m_hi[31:24] == 8'd0 && data[0]) begin
      m_halt = 1; m_pass = (data == 32'd1); m_code = data[31:1]; m_timeout = 0;
      stopped = 1;
    end
`ifdef HTIF_CONSOLE_EN
    else if (full && addr == TOHOST && m_hi[31:24] == 8'd1 && m_hi[23:16] == 8'd1) begin
      m_char_v = 1;
      exp_q.push_back(data[7:0]);
    end
`endif
    if (!stopped && nc == TIMEOUT) begin
      m_halt = 1; m_timeout = 1; m_pass = 0; m_code = 0;
      stopped = 1;
    end
    m_cycles = nc;
    if (stopped) begin
      m_running = 0;
      m_since   = 0;
    end
  endfunction

  task automatic compare_model();
    bit          m_done;
    htif_state_e exp_st;
    m_done = !m_running && (m_since >= DRAIN + 1);
    exp_st = m_running ? ST_RUN : (m_done ? ST_DONE : ST_DRAIN);
    check("halt",        halt,        m_halt);
    check("done",        done,        m_done);
    check("pass",        pass,        m_pass);
    check("exit_code",   exit_code,   m_code);
    check("timeout",     timeout,     m_timeout);
    check("cycle_count", cycle_count, 32'(m_cycles));
    check("state",       32'(state),  32'(exp_st));
    check("char_valid",  char_valid,  m_char_v);
    if (char_valid && exp_q.size() > 0) check("char_data", char_data, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit sv, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input bit rst);
    reset                = rst;
    bus_if.storeValid    = sv;
    bus_if.d_address     = addr;
    bus_if.storeData     = data;
    bus_if.byteEnable    = be;
    @(posedge clock);
    #1;
    model_step(sv, addr, data, be, rst);
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    cycle(1'b1, addr, data, be, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  hi_be;
    logic [31:0] hi_data;
    logic [31:0] lo_addr;
    logic [31:0] lo_data;
    logic [3:0]  lo_be;
    bit          exp_halt;
    bit          exp_pass;
    logic [30:0] exp_code;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    vecs[0] = '{4'hF, 32'h0000_0000, TOHOST,         32'h0000_0001, 4'hF,    1'b1, 1'b1, 31'd0};
    vecs[1] = '{4'hF, 32'h0000_0000, TOHOST,         32'h0000_0007, 4'hF,    1'b1, 1'b0, 31'd3};
    vecs[2] = '{4'hF, 32'h0000_0000, TOHOST,         32'h0000_0000, 4'hF,    1'b0, 1'b0, 31'd0};
    vecs[3] = '{4'hF, 32'h0000_0000, TOHOST,         32'h0000_0001, 4'b0001, 1'b0, 1'b0, 31'd0};
    vecs[4] = '{4'hF, 32'h0000_0000, TOHOST + 32'd8, 32'h0000_0001, 4'hF,    1'b0, 1'b0, 31'd0};
    vecs[5] = '{4'hF, 32'h0101_0000, TOHOST,         32'h0000_0041, 4'hF,    1'b0, 1'b0, 31'd0};
    vecs[6] = '{4'hF, 32'h0200_0000, TOHOST,         32'h0000_0001, 4'hF,    1'b0, 1'b0, 31'd0};
    vecs[7] = '{4'hF, 32'h0000_0000, TOHOST,         32'hFFFF_FFFF, 4'hF,    1'b1, 1'b0, 31'h7FFF_FFFF};
    vecs[8] = '{4'hE, 32'h0500_0000, TOHOST,         32'h0000_0001, 4'hF,    1'b1, 1'b1, 31'd0};
    vecs[9] = '{4'hF, 32'h0000_1234, TOHOST,         32'h0000_0011, 4'hF,    1'b1, 1'b0, 31'd8};

    do_reset();
    check("reset_halt",  halt, 1'b0);
    check("reset_count", cycle_count, 32'd0);
    check("reset_state", 32'(state), 32'(ST_RUN));

    for (int i = 0; i < 10; i++) begin
      do_reset();
      store(TOHOST + 32'd4, vecs[i].hi_data, vecs[i].hi_be);
      store(vecs[i].lo_addr, vecs[i].lo_data, vecs[i].lo_be);
      check($sformatf("vec%0d_halt", i),    halt,      vecs[i].exp_halt);
      check($sformatf("vec%0d_pass", i),    pass,      vecs[i].exp_pass);
      check($sformatf("vec%0d_code", i),    exit_code, vecs[i].exp_code);
      check($sformatf("vec%0d_timeout", i), timeout,   1'b0);
      if (vecs[i].exp_halt) begin
        n = 0;
        while (!done && n < 20) begin idle(1); n++; end
        check($sformatf("vec%0d_done_edges", i), n, DRAIN + 1);
        store(TOHOST, 32'h0000_0003, 4'hF);
        check($sformatf("vec%0d_hold_pass", i), pass,      vecs[i].exp_pass);
        check($sformatf("vec%0d_hold_code", i), exit_code, vecs[i].exp_code);
      end else begin
        idle(DRAIN + 2);
        check($sformatf("vec%0d_no_done", i), done, 1'b0);
      end
    end

    // watchdog timeout with no stores
    do_reset();
    n = 0;
    while (!halt && n < TIMEOUT + 20) begin idle(1); n++; end
    check("to_edges", n, TIMEOUT);
    check("to_flag",  timeout, 1'b1);
    check("to_count", cycle_count, TIMEOUT);
    check("to_pass",  pass, 1'b0);
    idle(10);
    check("to_count_hold", cycle_count, TIMEOUT);
    check("to_done",       done, 1'b1);

    // exit write lands on the edge where the count reaches TIMEOUT
    do_reset();
    idle(TIMEOUT - 1);
    store(TOHOST, 32'h0000_0001, 4'hF);
    check("sim_halt",    halt, 1'b1);
    check("sim_pass",    pass, 1'b1);
    check("sim_timeout", timeout, 1'b0);
    check("sim_count",   cycle_count, TIMEOUT);

    // masked write, then reset mid-DRAIN
    do_reset();
    store(TOHOST, 32'h0000_0001, 4'b0001);
    check("mask_halt", halt, 1'b0);
    store(TOHOST, 32'h0000_0001, 4'hF);
    idle(2);
    check("mid_drain_state", 32'(state), 32'(ST_DRAIN));
    do_reset();
    check("rst_drain_halt",  halt, 1'b0);
    check("rst_drain_pass",  pass, 1'b0);
    check("rst_drain_count", cycle_count, 32'd0);
    check("rst_drain_state", 32'(state), 32'(ST_RUN));

    // reset in DONE, then reset coincident with an exit write
    store(TOHOST, 32'h0000_0007, 4'hF);
    idle(DRAIN + 2);
    check("done_before_rst", done, 1'b1);
    do_reset();
    check("rst_done_done", done, 1'b0);
    check("rst_done_code", exit_code, 31'd0);
    cycle(1'b1, TOHOST, 32'h0000_0001, 4'hF, 1'b1);
    check("rst_exit_halt",  halt, 1'b0);
    check("rst_exit_state", 32'(state), 32'(ST_RUN));

`ifdef HTIF_CONSOLE_EN
    do_reset();
    store(TOHOST + 32'd4, 32'h0101_0000, 4'hF);
    store(TOHOST, 32'h0000_0041, 4'hF);
    check("con_valid", char_valid, 1'b1);
    check("con_data",  char_data, 8'h41);
    check("con_halt",  halt, 1'b0);
    idle(1);
    check("con_pulse_end", char_valid, 1'b0);
`endif

    // randomized stores against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] addr, data;
      logic [3:0]  be;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 40) begin
        case ($urandom_range(0, 3))
          0:       addr = TOHOST;
          1:       addr = TOHOST + 32'd4;
          2:       addr = TOHOST + 32'd8;
          default: addr = $urandom;
        endcase
        be = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        if (addr == TOHOST + 32'd4) begin
          data = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 1)), 16'($urandom)};
        end else begin
          data = $urandom;
          if ($urandom_range(0, 7) != 0) data[0] = 1'b0;
          if ($urandom_range(0, 3) == 0) data = 32'd1;
        end
        store(addr, data, be);
      end else begin
        idle(1);
      end
    end

    check("char_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/htif_monitor.md
HTIF_MONITOR -- requirements
Module: htif_monitor

Interface
REQ-001 SHALL have parameter TOHOST, default 32'h0000_1000, byte address of the HTIF tohost low word.
REQ-002 SHALL have parameter TIMEOUT, default 200_000, the number of RUN cycles before a forced stop.
REQ-003 SHALL have parameter DRAIN, default 4, the number of cycles between halt detection and done.
REQ-004 SHALL have port clock, input, 1, the single system clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port storeValid, input, 1, data-memory store strobe.
REQ-007 SHALL have port d_address, input, 32, store byte address.
REQ-008 SHALL have port storeData, input, 32, store data.
REQ-009 SHALL have port byteEnable, input, 4, store byte lanes.
REQ-010 SHALL have port halt, output, 1, asserted once a halt (exit or timeout) is accepted.
REQ-011 SHALL have port done, output, 1, asserted when DRAIN has elapsed after halt; this is the signature-dump trigger.
REQ-012 SHALL have port pass, output, 1, the exit value was 1.
REQ-013 SHALL have port exit_code, output, 31, storeData[31:1] of the exit write.
REQ-014 SHALL have port timeout, output, 1, the stop was caused by the watchdog.
REQ-015 SHALL have port char_valid, output, 1, a one-cycle console character strobe.
REQ-016 SHALL have port char_data, output, 8, the console character.
REQ-017 SHALL have port cycle_count, output, 32, the number of RUN cycles elapsed.

Function
REQ-018 SHALL implement the FSM RUN -> DRAIN -> DONE; DONE is terminal until reset.
REQ-019 SHALL treat a store as an HTIF write only if storeValid is high, byteEnable is 4'b1111, and d_address equals TOHOST or TOHOST+4.
REQ-020 SHALL, on a write to TOHOST+4, latch hi_word = storeData (device = [31:24], cmd = [23:16]) with no other effect.
REQ-021 SHALL, on a write to TOHOST with device==0 and storeData[0]==1 in RUN, register the exit on the following clock edge:
- halt=1, pass=(storeData==1), exit_code=storeData[31:1];
- state goes to DRAIN.
REQ-022 SHALL ignore a write to TOHOST with device==0 and storeData[0]==0 (no state change).
REQ-023 SHALL increment cycle_count every RUN cycle.
REQ-024 SHALL, when cycle_count reaches TIMEOUT, set halt=1, timeout=1, pass=0, exit_code=0, and go to DRAIN.
REQ-025 SHALL give an exit write priority when it occurs in the same cycle as the timeout condition: timeout stays 0.
REQ-026 SHALL count DRAIN cycles in the DRAIN state, then enter DONE with done=1; done is first high exactly DRAIN+1 edges after the exit write is sampled.
REQ-027 SHALL ignore all stores in DRAIN and DONE; halt, pass, exit_code and timeout hold their values.
REQ-028 SHALL saturate cycle_count at 32'hFFFF_FFFF and stop counting outside RUN.
REQ-029 SHALL ignore partial-lane writes to TOHOST/TOHOST+4, including any hi_word update.

Reset
REQ-030 SHALL, on reset high at a clock edge, force state=RUN, and clear halt, done, pass, exit_code, timeout, char_valid, char_data, cycle_count, hi_word and the drain counter.
REQ-031 SHALL return to RUN with all outputs cleared if reset is asserted mid-DRAIN or in DONE; no output is retained.
REQ-032 SHALL, if reset is asserted in the same cycle as an exit write, ignore that write.

Configuration
REQ-033 SHALL compile in the console when macro HTIF_CONSOLE_EN is defined: a RUN write to TOHOST with device==1 and cmd==1 gives char_valid=1 for one cycle and char_data=storeData[7:0] on the next edge.
REQ-034 SHALL, without HTIF_CONSOLE_EN, tie char_valid and char_data to 0 and treat device-1 writes as ignored.

Structure
REQ-035 SHALL put in the shared package htif_pkg:
- the state enum (RUN, DRAIN, DONE);
- constants HTIF_DEV_SYSCALL=8'd0, HTIF_DEV_CONSOLE=8'd1, HTIF_CMD_PUTCHAR=8'd1.
REQ-036 SHALL instantiate one sub-module, htif_watchdog, containing the saturating cycle counter and the timeout compare.

Verification
REQ-037 SHALL cover exit pass: write TOHOST+4=0, then TOHOST=32'h1 -> halt=1, pass=1, exit_code=0; done 5 edges later (DRAIN=4).
REQ-038 SHALL cover exit fail: TOHOST=32'h0000_0007 -> pass=0, exit_code=3, timeout=0.
REQ-039 SHALL cover timeout: TIMEOUT=100 with no stores -> halt=1 and timeout=1 when cycle_count=100; cycle_count holds at 100.
REQ-040 SHALL cover the simultaneous case: an exit write TOHOST=32'h1 in the same cycle cycle_count reaches TIMEOUT -> pass=1, timeout=0.
REQ-041 SHALL cover the console with HTIF_CONSOLE_EN: TOHOST+4=32'h0101_0000, then TOHOST=32'h41 -> a single char_valid pulse with char_data=8'h41; halt stays 0.
REQ-042 SHALL cover mask and reset: byteEnable=4'b0001 write of 1 to TOHOST -> no halt; then reset mid-DRAIN -> all outputs 0 and state RUN.
